// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter:
// FSM state encodings and the default word width.
package piso_shift_tx_pkg;

   // Two-state controller; encodings are fixed so that downstream tools and
   // waveform viewers always see IDLE as 0 and SHIFT as 1.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } tx_state_t;

   // Word width used when the instantiating block does not override it.
   localparam int DEFAULT_WIDTH = 8;

endpackage : piso_shift_tx_pkg

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle of the transmitter.
// The master side supplies words and stall; the slave side is the
// transmitter itself, which returns ready, the serial stream and status.
interface piso_shift_tx_if
   import piso_shift_tx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] ld_data;
   logic             ld_valid;
   logic             ld_ready;
   logic             stall;
   logic             q;
   logic             q_valid;
   logic             busy;
   logic             done;

   modport master (
      output ld_data,
      output ld_valid,
      output stall,
      input  ld_ready,
      input  q,
      input  q_valid,
      input  busy,
      input  done
   );

   modport slave (
      input  ld_data,
      input  ld_valid,
      input  stall,
      output ld_ready,
      output q,
      output q_valid,
      output busy,
      output done
   );

endinterface : piso_shift_tx_if

// File: rtl/piso_shift_tx.sv
// Parallel-in / serial-out transmitter. A word is taken through a
// valid/ready handshake and presented one bit per clock on q, with q_valid
// marking every data bit and a single-cycle done pulse after the last one.
// q is registered and the status outputs decode straight from the state
// register, so neither ld_valid nor stall has a combinational path to q.
module piso_shift_tx
   import piso_shift_tx_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit LSB_FIRST = 1'b1,
   parameter bit IDLE_LVL  = 1'b1
) (
   input logic            clock,
   input logic            clear,
   piso_shift_tx_if.slave bus
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

   tx_state_t        state;
   tx_state_t        next_state;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shifted_reg;
   logic [CW-1:0]    bit_count;
   logic             q_reg;
   logic             done_reg;
   logic             first_bit;
   logic             next_bit;
   logic             load_word;
   logic             advance_bit;
   logic             finish_word;

   // State register; clear aborts any word in flight immediately.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and the three datapath strobes (load, advance, finish).
   always_comb begin
      next_state  = state;
      load_word   = 1'b0;
      advance_bit = 1'b0;
      finish_word = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.ld_valid) begin
               load_word  = 1'b1;
               next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!bus.stall) begin
               if (bit_count == LAST_IDX) begin
                  finish_word = 1'b1;
                  next_state  = ST_IDLE;
               end else begin
                  advance_bit = 1'b1;
               end
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Bit-order selection: which bit goes out on load, which follows it, and
   // how the register moves so the following bit is always in the same place.
   always_comb begin
      first_bit   = 1'b0;
      next_bit    = 1'b0;
      shifted_reg = shift_reg;
      if (LSB_FIRST) begin
         first_bit   = bus.ld_data[0];
         next_bit    = shift_reg[1];
         shifted_reg = {1'b0, shift_reg[WIDTH-1:1]};
      end else begin
         first_bit   = bus.ld_data[WIDTH-1];
         next_bit    = shift_reg[WIDTH-2];
         shifted_reg = {shift_reg[WIDTH-2:0], 1'b0};
      end
   end

   // Shift register, bit counter, serial output and done pulse. A stalled
   // cycle asserts none of the strobes, so everything simply holds.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         shift_reg <= '0;
         bit_count <= '0;
         q_reg     <= IDLE_LVL;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= finish_word;
         if (load_word) begin
            shift_reg <= bus.ld_data;
            bit_count <= '0;
            q_reg     <= first_bit;
         end else if (advance_bit) begin
            shift_reg <= shifted_reg;
            bit_count <= bit_count + CW'(1);
            q_reg     <= next_bit;
         end else if (finish_word) begin
            q_reg <= IDLE_LVL;
         end
      end
   end

   assign bus.q        = q_reg;
   assign bus.q_valid  = (state == ST_SHIFT);
   assign bus.busy     = (state == ST_SHIFT);
   assign bus.ld_ready = (state == ST_IDLE);
   assign bus.done     = done_reg;

endmodule : piso_shift_tx

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: one LSB-first and one MSB-first
// instance, each on its own interface, with hand-computed bit sequences.
module tb_piso_shift_tx;
   import piso_shift_tx_pkg::*;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic [7:0] ld_data = 8'h00;
   logic       ld_valid = 1'b0;
   logic       stall = 1'b0;
   logic       use_msb = 1'b0;

   int errors = 0;
   int checks = 0;

   logic obs_q, obs_q_valid, obs_busy, obs_ready, obs_done;

   piso_shift_tx_if #(.WIDTH(8)) bus_lsb ();
   piso_shift_tx_if #(.WIDTH(8)) bus_msb ();

   assign bus_lsb.ld_data  = ld_data;
   assign bus_lsb.ld_valid = ld_valid & ~use_msb;
   assign bus_lsb.stall    = stall & ~use_msb;
   assign bus_msb.ld_data  = ld_data;
   assign bus_msb.ld_valid = ld_valid & use_msb;
   assign bus_msb.stall    = stall & use_msb;

   assign obs_q       = use_msb ? bus_msb.q        : bus_lsb.q;
   assign obs_q_valid = use_msb ? bus_msb.q_valid  : bus_lsb.q_valid;
   assign obs_busy    = use_msb ? bus_msb.busy     : bus_lsb.busy;
   assign obs_ready   = use_msb ? bus_msb.ld_ready : bus_lsb.ld_ready;
   assign obs_done    = use_msb ? bus_msb.done     : bus_lsb.done;

   piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_lsb (
      .clock (clock),
      .clear (clear),
      .bus   (bus_lsb)
   );

   piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_msb (
      .clock (clock),
      .clear (clear),
      .bus   (bus_msb)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input string what,
                              input logic observed, input logic expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s.%s observed=%0b expected=%0b", tag, what, observed, expected);
      end
   endtask

   task automatic checkCount(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Loads one word, walks its bits (optionally stalling on one of them) and
   // checks the done cycle. seq holds the expected bits in send order.
   task automatic applyStimulus(input logic [7:0] data, input logic [0:7] seq,
                                input int stall_bit, input int stall_len, input string tag);
      int busy_cycles;
      busy_cycles = 0;
      ld_data  = data;
      ld_valid = 1'b1;
      step();
      ld_valid = 1'b0;
      for (int b = 0; b < 8; b++) begin
         checkOutput(tag, $sformatf("q%0d", b), obs_q, seq[b]);
         checkOutput(tag, "q_valid", obs_q_valid, 1'b1);
         checkOutput(tag, "ld_ready_busy", obs_ready, 1'b0);
         if (obs_busy) busy_cycles++;
         if (b == stall_bit) begin
            stall = 1'b1;
            for (int s = 0; s < stall_len; s++) begin
               step();
               checkOutput(tag, $sformatf("hold%0d", s), obs_q, seq[b]);
               checkOutput(tag, "hold_q_valid", obs_q_valid, 1'b1);
               if (obs_busy) busy_cycles++;
            end
            stall = 1'b0;
         end
         step();
      end
      checkOutput(tag, "done", obs_done, 1'b1);
      checkOutput(tag, "ld_ready_done", obs_ready, 1'b1);
      checkOutput(tag, "q_idle", obs_q, 1'b1);
      checkOutput(tag, "q_valid_idle", obs_q_valid, 1'b0);
      checkOutput(tag, "busy_idle", obs_busy, 1'b0);
      checkCount({tag, ".busy_cycles"}, busy_cycles, 8 + stall_len);
      step();
      checkOutput(tag, "done_pulse_end", obs_done, 1'b0);
   endtask

   initial begin
      // T1: asynchronous reset takes effect before any clock edge
      #2 clear = 1'b0;
      #2;
      checkOutput("T1", "q", obs_q, 1'b1);
      checkOutput("T1", "q_valid", obs_q_valid, 1'b0);
      checkOutput("T1", "ld_ready", obs_ready, 1'b1);
      checkOutput("T1", "busy", obs_busy, 1'b0);
      checkOutput("T1", "done", obs_done, 1'b0);
      step();
      clear = 1'b1;
      step();

      // T2: LSB-first 8'hA5 -> 1,0,1,0,0,1,0,1
      applyStimulus(8'hA5, 8'b1010_0101, -1, 0, "T2");

      // T3: MSB-first 8'h81 -> 1,0,0,0,0,0,0,1
      use_msb = 1'b1;
      applyStimulus(8'h81, 8'b1000_0001, -1, 0, "T3");
      use_msb = 1'b0;

      // T4: 8'h0F -> 1,1,1,1,0,0,0,0 with bit 4 stalled 3 extra cycles
      applyStimulus(8'h0F, 8'b1111_0000, 4, 3, "T4");

      // T5: ld_valid held high across two words 8'h3C then 8'hC3
      ld_data  = 8'h3C;
      ld_valid = 1'b1;
      step();
      ld_data = 8'hC3;
      for (int b = 0; b < 8; b++) begin
         checkOutput("T5a", $sformatf("q%0d", b), obs_q, logic'(8'b0011_1100 >> (7 - b)));
         checkOutput("T5a", "q_valid", obs_q_valid, 1'b1);
         step();
      end
      checkOutput("T5a", "done", obs_done, 1'b1);
      checkOutput("T5a", "ld_ready", obs_ready, 1'b1);
      checkOutput("T5a", "q_idle", obs_q, 1'b1);
      checkOutput("T5a", "q_valid_idle", obs_q_valid, 1'b0);
      step();
      ld_valid = 1'b0;
      checkOutput("T5b", "done_end", obs_done, 1'b0);
      for (int b = 0; b < 8; b++) begin
         checkOutput("T5b", $sformatf("q%0d", b), obs_q, logic'(8'b1100_0011 >> (7 - b)));
         checkOutput("T5b", "q_valid", obs_q_valid, 1'b1);
         step();
      end
      checkOutput("T5b", "done", obs_done, 1'b1);
      step();

      // T6: clear pulsed during bit 5 of 8'hFF, then 8'h00 sent cleanly
      ld_data  = 8'hFF;
      ld_valid = 1'b1;
      step();
      ld_valid = 1'b0;
      for (int b = 0; b < 5; b++) begin
         checkOutput("T6a", $sformatf("q%0d", b), obs_q, 1'b1);
         step();
      end
      checkOutput("T6a", "q_valid5", obs_q_valid, 1'b1);
      #2 clear = 1'b0;
      #1;
      checkOutput("T6a", "rst_q", obs_q, 1'b1);
      checkOutput("T6a", "rst_q_valid", obs_q_valid, 1'b0);
      checkOutput("T6a", "rst_busy", obs_busy, 1'b0);
      checkOutput("T6a", "rst_ld_ready", obs_ready, 1'b1);
      checkOutput("T6a", "rst_done", obs_done, 1'b0);
      clear = 1'b1;
      step();
      checkOutput("T6a", "no_done1", obs_done, 1'b0);
      checkOutput("T6a", "busy_after", obs_busy, 1'b0);
      step();
      checkOutput("T6a", "no_done2", obs_done, 1'b0);
      applyStimulus(8'h00, 8'b0000_0000, -1, 0, "T6b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_piso_shift_tx
